// File: rtl/vec_dot_mac.sv
// vec_dot_mac: multi-cycle signed fixed-point dot product engine.
// LANES multiply-accumulates per beat into a full-precision accumulator,
// then a final beat rescales by BIN_POS and saturates or wraps to DATA_WIDTH.
module vec_dot_mac #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned BIN_POS     = 8,
  parameter int unsigned VECTOR_SIZE = 4,
  parameter int unsigned LANES       = 1,
  parameter int unsigned SATURATE    = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] vec_a,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] vec_b,
  output logic                              busy,
  output logic                              complete,
  output logic [DATA_WIDTH-1:0]             dot,
  output logic                              overflow
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned PW    = 2 * DATA_WIDTH;
  localparam int unsigned ACC_W = PW + $clog2(VECTOR_SIZE) + 1;
  localparam int unsigned IDX_W = $clog2(VECTOR_SIZE + LANES) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [DW-1:0]            r_a [VECTOR_SIZE];
  logic [DW-1:0]            r_b [VECTOR_SIZE];
  logic signed [ACC_W-1:0]  r_acc, w_acc_nxt;
  logic [IDX_W-1:0]         r_idx, w_idx_nxt;
  logic                     r_busy, w_busy_nxt;
  logic                     r_complete, w_complete_nxt;
  logic [DW-1:0]            r_dot, w_dot_nxt;
  logic                     r_overflow, w_overflow_nxt;
  logic                     w_load;

  logic [DW-1:0]            w_la [LANES];
  logic [DW-1:0]            w_lb [LANES];
  logic signed [PW-1:0]     w_prod [LANES];
  logic signed [ACC_W-1:0]  w_beat_sum;
  logic                     w_last_beat;

  logic signed [ACC_W-1:0]  w_shift;
  logic [ACC_W-DW:0]        w_hi;
  logic                     w_range_ovf;
  logic [DW-1:0]            w_clamp;
  logic [DW-1:0]            w_result;

  assign busy     = r_busy;
  assign complete = r_complete;
  assign dot      = r_dot;
  assign overflow = r_overflow;

  // Lane datapath: pick element idx+lane per lane (zero past the end), multiply, sum the beat
  always_comb begin
    w_beat_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      w_la[l] = '0;
      w_lb[l] = '0;
      for (int j = 0; j < VECTOR_SIZE; j++) begin
        if (r_idx + IDX_W'(l) == IDX_W'(j)) begin
          w_la[l] = r_a[j];
          w_lb[l] = r_b[j];
        end
      end
      w_prod[l]  = $signed({{DW{w_la[l][DW-1]}}, w_la[l]}) *
                   $signed({{DW{w_lb[l][DW-1]}}, w_lb[l]});
      w_beat_sum = w_beat_sum + $signed({{(ACC_W-PW){w_prod[l][PW-1]}}, w_prod[l]});
    end
    w_last_beat = (r_idx + IDX_W'(LANES)) >= IDX_W'(VECTOR_SIZE);
  end

  // Rescale by floor shift, then detect out-of-range and clamp or wrap
  always_comb begin
    w_shift     = r_acc >>> BIN_POS;
    w_hi        = w_shift[ACC_W-1:DW-1];
    w_range_ovf = ~((&w_hi) | ~(|w_hi));
    w_clamp     = w_shift[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    if (w_range_ovf && (SATURATE != 0)) begin
      w_result = w_clamp;
    end else begin
      w_result = w_shift[DW-1:0];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_idx_nxt      = r_idx;
    w_busy_nxt     = r_busy;
    w_complete_nxt = r_complete;
    w_dot_nxt      = r_dot;
    w_overflow_nxt = r_overflow;
    w_load         = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_load         = 1'b1;
          w_acc_nxt      = '0;
          w_idx_nxt      = '0;
          w_busy_nxt     = 1'b1;
          w_complete_nxt = 1'b0;
          w_overflow_nxt = 1'b0;
          w_state_nxt    = S_RUN;
        end
      end
      S_RUN: begin
        w_acc_nxt = r_acc + w_beat_sum;
        w_idx_nxt = r_idx + IDX_W'(LANES);
        if (w_last_beat) begin
          w_state_nxt = S_FINAL;
        end
      end
      S_FINAL: begin
        w_dot_nxt      = w_result;
        w_overflow_nxt = w_range_ovf;
        w_complete_nxt = 1'b1;
        w_busy_nxt     = 1'b0;
        w_state_nxt    = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, accumulator and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_complete <= 1'b0;
      r_dot      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_idx      <= w_idx_nxt;
      r_busy     <= w_busy_nxt;
      r_complete <= w_complete_nxt;
      r_dot      <= w_dot_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  // Operand capture on an accepted start; inputs are free to change afterwards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else if (w_load) begin
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        r_a[i] <= vec_a[i*DW +: DW];
        r_b[i] <= vec_b[i*DW +: DW];
      end
    end
  end

endmodule
